fc_act_loader: RTL and testbench

FC_ACT_LOADER -- requirements
Module: fc_act_loader

---
 rtl/fc_loader_pkg.sv | 14 +
 rtl/fc_act_loader_if.sv | 36 +++
 rtl/fc_act_loader.sv | 85 ++++++++
 tb/tb_fc_act_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_loader_pkg.sv
// Shared types for the activation loader: FSM state encoding and index width.
// The index is sized from IN so it can never address past the last entry.
package fc_loader_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_act_loader_if.sv
// Beat-in / vector-out bundle for fc_act_loader; in_last and err exist only
// when FC_LOADER_LAST_CHECK_EN is defined.
interface fc_act_loader_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;
`ifdef FC_LOADER_LAST_CHECK_EN
  logic             in_last;
  logic             err;
`endif

  modport slave (
    input  in_data, in_valid, x_ready,
    output in_ready, x, x_valid
`ifdef FC_LOADER_LAST_CHECK_EN
    , input in_last
    , output err
`endif
  );

  modport master (
    output in_data, in_valid, x_ready,
    input  in_ready, x, x_valid
`ifdef FC_LOADER_LAST_CHECK_EN
    , output in_last
    , input err
`endif
  );

endinterface

// File: rtl/fc_act_loader.sv
// Collects IN activation beats into a parallel flop vector; x_valid 1 clock after the closing beat,
// input stalled (in_ready=0) while the vector is held. Optional framing check: FC_LOADER_LAST_CHECK_EN.
module fc_act_loader
  import fc_loader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_act_loader_if.slave bus
);

  localparam int            IW       = idx_width(IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x_q [0:IN-1];
  logic             live;
  logic             accept;
  logic             at_last;
  logic             close;
  logic             release_vec;
`ifdef FC_LOADER_LAST_CHECK_EN
  logic             bad_frame;
  logic             err_q;
`endif

  always_comb begin
    state_nxt   = state;
    at_last     = (idx == LAST_IDX);
    accept      = live && (state == FILL) && bus.in_valid;
    release_vec = (state == HOLD) && bus.x_ready;
`ifdef FC_LOADER_LAST_CHECK_EN
    close       = accept && (at_last || bus.in_last);
    bad_frame   = accept && (at_last != bus.in_last);
`else
    close       = accept && at_last;
`endif
    case (state)
      FILL:    if (close) state_nxt = HOLD;
      HOLD:    if (bus.x_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // live holds in_ready low for the reset period and the edge it is released on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      for (int i = 0; i < IN; i++) x_q[i] <= '0;
    end else if (release_vec) begin
      idx <= '0;
      for (int i = 0; i < IN; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[idx] <= bus.in_data;
      if (!at_last) idx <= idx + 1'b1;
    end
  end

`ifdef FC_LOADER_LAST_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (bad_frame) err_q <= 1'b1;
  end
  assign bus.err = err_q;
`endif

  assign bus.in_ready = live && (state == FILL);
  assign bus.x_valid  = (state == HOLD);
  assign bus.x        = x_q;

endmodule

// File: tb/tb_fc_act_loader.sv
// Randomized bench for fc_act_loader: a vector-level model (expected array) is built from accepted beats.
module tb_fc_act_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_act_loader_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

  fc_act_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] stim    [0:IN-1];
  logic [WIDTH-1:0] exp_vec [0:IN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int diff_count();
    int d = 0;
    for (int k = 0; k < IN; k++)
      if (bus.x[k] !== exp_vec[k]) d++;
    return d;
  endfunction

  task automatic clear_exp();
    for (int k = 0; k < IN; k++) exp_vec[k] = '0;
  endtask

  task automatic rand_stim();
    for (int k = 0; k < IN; k++) stim[k] = WIDTH'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    clear_exp();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_x_valid", 32'(bus.x_valid), 0);
    check("rst_x_zero", diff_count(), 0);
`ifdef FC_LOADER_LAST_CHECK_EN
    check("rst_err", 32'(bus.err), 0);
`endif
    @(negedge clk) rst_n = 1'b1;
    check("rst_ready_low_at_release", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1 check("rst_ready_rise", 32'(bus.in_ready), 1);
  endtask

  // Offers stim[0..n-1] with random gaps; the model records each accepted beat.
  task automatic send(input int n, input int gap_pct, input bit close_last, input bit rand_xr);
    int   sent = 0;
    int   cyc  = 0;
    logic acc;
    while (sent < n && cyc < n * 20 + 50) begin
      @(negedge clk);
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      bus.in_data  = bus.in_valid ? stim[sent] : WIDTH'($urandom);
`ifdef FC_LOADER_LAST_CHECK_EN
      bus.in_last  = close_last && (sent == n - 1);
`else
      if (close_last && sent < 0) bus.in_data = '0;
`endif
      bus.x_ready  = rand_xr ? 1'($urandom_range(1)) : 1'b0;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      cyc++;
      if (acc) begin
        exp_vec[sent] = stim[sent];
        sent++;
      end
    end
    check("send_done", sent, n);
    #1;
    bus.in_valid = 1'b0;
    bus.x_ready  = 1'b0;
`ifdef FC_LOADER_LAST_CHECK_EN
    bus.in_last  = 1'b0;
`endif
  endtask

  task automatic expect_vector(input string tag);
    check({tag, "_x_valid"}, 32'(bus.x_valid), 1);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_x_diff"}, diff_count(), 0);
  endtask

  task automatic release_vec(input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.x_ready  = 1'b0;
      @(posedge clk);
      #1;
      check("hold_in_ready", 32'(bus.in_ready), 0);
      check("hold_x_valid", 32'(bus.x_valid), 1);
      check("hold_x_stable", diff_count(), 0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.x_ready = 1'b0;
    clear_exp();
    check("rel_x_valid", 32'(bus.x_valid), 0);
    check("rel_in_ready", 32'(bus.in_ready), 1);
    check("rel_x_zero", diff_count(), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.x_ready  = 1'b0;
`ifdef FC_LOADER_LAST_CHECK_EN
    bus.in_last  = 1'b0;
`endif
    do_reset();

    // Ramp 0..IN-1 back-to-back, released the cycle it appears
    for (int k = 0; k < IN; k++) stim[k] = WIDTH'(k);
    clear_exp();
    send(IN, 0, 1'b1, 1'b0);
    expect_vector("ramp");
    release_vec(0);

    // Held for 10 cycles against a pushy source
    rand_stim();
    clear_exp();
    send(IN, 0, 1'b1, 1'b1);
    expect_vector("hold");
    release_vec(10);

    // Two vectors with ~50% gaps; x_ready toggles during fill and must be ignored
    for (int v = 0; v < 2; v++) begin
      rand_stim();
      clear_exp();
      send(IN, 50, 1'b1, 1'b1);
      expect_vector("gaps");
      release_vec($urandom_range(0, 3));
    end

    // Reset after beat 60 discards the partial vector
    rand_stim();
    clear_exp();
    send(61, 30, 1'b0, 1'b0);
    check("partial_no_valid", 32'(bus.x_valid), 0);
    do_reset();
    rand_stim();
    clear_exp();
    send(IN, 0, 1'b1, 1'b0);
    expect_vector("restart");
    release_vec(1);

`ifdef FC_LOADER_LAST_CHECK_EN
    check("err_clean", 32'(bus.err), 0);
    // Early in_last on beat 5 closes a short vector
    for (int k = 0; k < IN; k++) stim[k] = WIDTH'(k + 1);
    clear_exp();
    send(6, 0, 1'b1, 1'b0);
    expect_vector("early");
    check("early_err", 32'(bus.err), 1);
    release_vec(2);
    rand_stim();
    clear_exp();
    send(IN, 20, 1'b1, 1'b0);
    expect_vector("after_err");
    check("err_sticky", 32'(bus.err), 1);
    release_vec(0);
    do_reset();
    // Missing in_last on the final beat still closes but flags err
    rand_stim();
    clear_exp();
    send(IN, 0, 1'b0, 1'b0);
    expect_vector("no_last");
    check("no_last_err", 32'(bus.err), 1);
    release_vec(0);
    do_reset();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
